// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard scheduler: tracker entry, forwarding-select
// encoding and the per-stage match helper.
package pipe_hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                  v;
      logic [REG_ADDR_W-1:0] rd;
      logic                  ld;
   } hz_entry_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_ALU = 2'd1,
      FWD_DM  = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   // Register 0 is hardwired, so it can never be the subject of a RAW hazard.
   function automatic logic stage_match(input logic [REG_ADDR_W-1:0] rs,
                                        input logic                  use_rs,
                                        input hz_entry_t             entry);
      return use_rs & (rs != ZERO_REG) & entry.v & (entry.rd == rs);
   endfunction

endpackage

// File: rtl/pipe_hazard_if.sv
// RF-stage instruction descriptor and hazard-control return path between the
// pipeline (master) and the hazard scheduler (slave).
interface pipe_hazard_if #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_rs1;
   logic [REG_ADDR_W-1:0]  id_rs2;
   logic                   id_uses_rs1;
   logic                   id_uses_rs2;
   logic [REG_ADDR_W-1:0]  id_rd;
   logic                   id_writes_rd;
   logic                   id_is_load;
   logic                   flush;
   logic                   stall;
   logic [1:0]             fwd_a_sel;
   logic [1:0]             fwd_b_sel;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_writes_rd, id_is_load, flush,
      input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_writes_rd, id_is_load, flush,
      output stall, fwd_a_sel, fwd_b_sel, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_cmp.sv
// Per-operand hazard comparator: matches one source against the EX/MEM/WB tracker.
// FORWARDING_EN selects bypassing (load-use stall only) instead of stall-on-any-match.
module pipe_hazard_cmp
   import pipe_hazard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  use_rs,
   input  hz_entry_t             ex,
   input  hz_entry_t             mem,
   input  hz_entry_t             wb,
   output fwd_sel_e              fwd_sel,
   output logic                  stall_req
);

   logic match_ex, match_mem, match_wb;
   logic unused_ld;

   assign match_ex  = stage_match(rs, use_rs, ex);
   assign match_mem = stage_match(rs, use_rs, mem);
   assign match_wb  = stage_match(rs, use_rs, wb);
   assign unused_ld = &{1'b0, mem.ld, wb.ld};

`ifdef FORWARDING_EN
   // A load in EX has no result to bypass yet: it claims priority but leaves RF selected.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      fwd_sel   = FWD_RF;
      stall_req = match_ex & ex.ld;
      if (match_ex) begin
         fwd_sel = ex.ld ? FWD_RF : FWD_ALU;
      end else if (match_mem) begin
         fwd_sel = FWD_DM;
      end else if (match_wb) begin
         fwd_sel = FWD_WB;
      end
   end
`else
   logic unused_ex_ld;
   assign unused_ex_ld = ex.ld;

   always_comb begin
      fwd_sel   = FWD_RF;
      stall_req = match_ex | match_mem | match_wb;
   end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the IF/RF/ALU/DM/WB pipeline: owns the EX/MEM/WB destination
// tracker and the saturating stall counter. Behaviour switches on FORWARDING_EN.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W  = pipe_hazard_pkg::REG_ADDR_W,
   parameter int STALL_CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   pipe_hazard_if.slave bus
);
   import pipe_hazard_pkg::*;

   hz_entry_t ex_q, ex_d;
   hz_entry_t mem_q, mem_d;
   hz_entry_t wb_q, wb_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   fwd_sel_e sel_a, sel_b;
   logic     req_a, req_b;
   logic     active;
   logic     stall;

   pipe_hazard_cmp u_cmp_a (
      .rs        (bus.id_rs1),
      .use_rs    (bus.id_uses_rs1),
      .ex        (ex_q),
      .mem       (mem_q),
      .wb        (wb_q),
      .fwd_sel   (sel_a),
      .stall_req (req_a)
   );

   pipe_hazard_cmp u_cmp_b (
      .rs        (bus.id_rs2),
      .use_rs    (bus.id_uses_rs2),
      .ex        (ex_q),
      .mem       (mem_q),
      .wb        (wb_q),
      .fwd_sel   (sel_b),
      .stall_req (req_b)
   );

   // Flush outranks stall: a redirected instruction must never hold the front end.
   assign active = ~reset & bus.id_valid & ~bus.flush;
   assign stall  = active & (req_a | req_b);

   assign bus.stall     = stall;
   assign bus.fwd_a_sel = active ? sel_a : FWD_RF;
   assign bus.fwd_b_sel = active ? sel_b : FWD_RF;
   assign bus.stall_cnt = stall_cnt_q;

   always_comb begin
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
      stall_cnt_d = stall_cnt_q;

      mem_d.v = ex_q.v & ~bus.flush;

      if (!(stall | bus.flush)) begin
         ex_d.v  = bus.id_valid & bus.id_writes_rd & (bus.id_rd != ZERO_REG);
         ex_d.rd = bus.id_rd;
         ex_d.ld = bus.id_is_load;
      end

      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end

      // NOTE: synchronous reset is folded into the next-state logic, so the flops stay plain.
      if (reset) begin
         ex_d        = '0;
         mem_d       = '0;
         wb_d        = '0;
         stall_cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// traffic, checked against an instruction-history model; a 4-bit counter copy checks saturation.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load, flush;
   logic [4:0] id_rs1, id_rs2, id_rd;

   pipe_hazard_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) bus16 ();
   pipe_hazard_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  bus4 ();

   assign bus16.id_valid     = id_valid;
   assign bus16.id_rs1       = id_rs1;
   assign bus16.id_rs2       = id_rs2;
   assign bus16.id_uses_rs1  = id_uses_rs1;
   assign bus16.id_uses_rs2  = id_uses_rs2;
   assign bus16.id_rd        = id_rd;
   assign bus16.id_writes_rd = id_writes_rd;
   assign bus16.id_is_load   = id_is_load;
   assign bus16.flush        = flush;
   assign bus4.id_valid      = id_valid;
   assign bus4.id_rs1        = id_rs1;
   assign bus4.id_rs2        = id_rs2;
   assign bus4.id_uses_rs1   = id_uses_rs1;
   assign bus4.id_uses_rs2   = id_uses_rs2;
   assign bus4.id_rd         = id_rd;
   assign bus4.id_writes_rd  = id_writes_rd;
   assign bus4.id_is_load    = id_is_load;
   assign bus4.flush         = flush;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(4)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: list of instructions issued past RF, newest first (index 0 = in ALU).
   typedef struct {
      bit v;
      int rd;
      bit ld;
   } ent_t;

   ent_t hist[$];
   int   exp_cnt;
   bit   exp_stall;
   logic last_stall;
   logic [3:0] last_cnt4;

   function automatic ent_t bubble();
      ent_t e;
      e.v = 0; e.rd = 0; e.ld = 0;
      return e;
   endfunction

   function automatic int hazard_dist(input int rs, input bit used);
      if (!used || rs == 0) return 0;
      for (int d = 0; d < hist.size(); d++)
         if (hist[d].v && hist[d].rd == rs) return d + 1;
      return 0;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(bubble());
      exp_cnt = 0;
   endtask

   task automatic model_step();
      ent_t e;
      if (reset) begin
         model_reset();
      end else begin
         if (flush) hist[0].v = 0;
         e = bubble();
         if (!(exp_stall || flush)) begin
            e.v  = id_valid && id_writes_rd && (id_rd != 0);
            e.rd = int'(id_rd);
            e.ld = id_is_load;
         end
         hist.push_front(e);
         void'(hist.pop_back());
         if (exp_stall) exp_cnt++;
      end
   endtask

   task automatic cycle(input string ph);
      int  da, db;
      bit  act;
      int  exp_a, exp_b;
      @(negedge clk);
      act   = !reset && id_valid && !flush;
      da    = hazard_dist(int'(id_rs1), id_uses_rs1);
      db    = hazard_dist(int'(id_rs2), id_uses_rs2);
      exp_a = 0;
      exp_b = 0;
      if (FWD) begin
         exp_stall = act && ((da == 1 || db == 1) && hist[0].ld);
         if (act) begin exp_a = da; exp_b = db; end
      end else begin
         exp_stall = act && (da != 0 || db != 0);
      end
      check({ph, ":stall"}, 32'(bus16.stall), 32'(exp_stall));
      check({ph, ":stall_w4"}, 32'(bus4.stall), 32'(exp_stall));
      // Operand selects are don't-care while the instruction is held.
      if (!exp_stall) begin
         check({ph, ":fwd_a"}, 32'(bus16.fwd_a_sel), 32'(exp_a));
         check({ph, ":fwd_b"}, 32'(bus16.fwd_b_sel), 32'(exp_b));
      end
      check({ph, ":cnt16"}, 32'(bus16.stall_cnt), (exp_cnt > 65535) ? 32'd65535 : 32'(exp_cnt));
      check({ph, ":cnt4"}, 32'(bus4.stall_cnt), (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
      last_stall = bus16.stall;
      last_cnt4  = bus4.stall_cnt;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_instr(input int rd, input bit wr, input int rs1, input bit u1,
                            input int rs2, input bit u2, input bit ld);
      id_valid     = 1'b1;
      id_rd        = 5'(rd);
      id_writes_rd = wr;
      id_rs1       = 5'(rs1);
      id_uses_rs1  = u1;
      id_rs2       = 5'(rs2);
      id_uses_rs2  = u2;
      id_is_load   = ld;
      flush        = 1'b0;
   endtask

   // Present one instruction and hold it in RF while the DUT stalls; returns stall cycles.
   task automatic issue(input string ph, input int rd, input bit wr, input int rs1, input bit u1,
                        input int rs2, input bit u2, input bit ld, output int stalls);
      set_instr(rd, wr, rs1, u1, rs2, u2, ld);
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(ph);
         if (last_stall !== 1'b1) break;
         stalls++;
      end
   endtask

   task automatic idle(input string ph, input int n);
      id_valid = 1'b0; flush = 1'b0;
      for (int i = 0; i < n; i++) cycle(ph);
   endtask

   int s;

   initial begin
      reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_writes_rd = 1'b0; id_is_load = 1'b0;
      model_reset();
      exp_stall = 0;
      @(posedge clk); #1;
      cycle("reset");
      cycle("reset");
      reset = 1'b0;
      idle("idle", 2);

      // ADD r3<-r1,r2 ; SUB r4<-r3,r5
      issue("add", 3, 1, 1, 1, 2, 1, 0, s);
      issue("sub_raw", 4, 1, 3, 1, 5, 1, 0, s);
      check("raw_adj_stalls", 32'(s), FWD ? 32'd0 : 32'd3);
      idle("idle", 4);

      // LW r7 ; ADD r8<-r7,r7
      issue("lw", 7, 1, 1, 1, 0, 0, 1, s);
      issue("lw_use", 8, 1, 7, 1, 7, 1, 0, s);
      check("load_use_stalls", 32'(s), FWD ? 32'd1 : 32'd3);
      idle("idle", 4);

      // ADD r0<-r1,r2 ; ADD r4<-r0,r0
      issue("wr_r0", 0, 1, 1, 1, 2, 1, 0, s);
      issue("rd_r0", 4, 1, 0, 1, 0, 1, 0, s);
      check("r0_stalls", 32'(s), 32'd0);
      idle("idle", 4);

      // r5 written at distance 2 and 1, then consumed
      issue("r5_a", 5, 1, 1, 1, 0, 0, 0, s);
      issue("r5_b", 5, 1, 2, 1, 0, 0, 0, s);
      issue("r5_use", 6, 1, 5, 1, 1, 1, 0, s);
      idle("idle", 4);

      // LW r9 ; consumer killed by flush ; later consumer sees nothing in flight
      issue("lw9", 9, 1, 1, 1, 0, 0, 1, s);
      set_instr(10, 1, 9, 1, 0, 0, 0);
      flush = 1'b1;
      cycle("flush");
      check("flush_stall", 32'(last_stall), 32'd0);
      issue("post_flush", 11, 1, 9, 1, 0, 0, 0, s);
      check("post_flush_stalls", 32'(s), 32'd0);
      idle("idle", 4);

      // Load-use pairs to drive the 4-bit counter into saturation
      for (int i = 0; i < 20; i++) begin
         issue("sat_lw", 9, 1, 1, 1, 0, 0, 1, s);
         issue("sat_use", 10, 1, 9, 1, 0, 0, 0, s);
         check("sat_pair_stalls", 32'(s), FWD ? 32'd1 : 32'd3);
      end
      idle("sat_hold", 2);
      check("sat_cnt4", 32'(last_cnt4), 32'd15);

      // Reset asserted while a load-use stall is pending
      issue("rst_lw", 9, 1, 1, 1, 0, 0, 1, s);
      set_instr(10, 1, 9, 1, 0, 0, 0);
      reset = 1'b1;
      cycle("rst_mid");
      check("rst_mid_stall", 32'(last_stall), 32'd0);
      reset = 1'b0;
      cycle("rst_after");
      check("rst_after_stall", 32'(last_stall), 32'd0);
      check("rst_after_cnt4", 32'(last_cnt4), 32'd0);
      idle("idle", 3);

      // Random traffic over a small register set to make hazards frequent
      for (int i = 0; i < 1500; i++) begin
         id_valid     = ($urandom_range(0, 7) != 0);
         id_rs1       = 5'($urandom_range(0, 7));
         id_rs2       = 5'($urandom_range(0, 7));
         id_rd        = 5'($urandom_range(0, 7));
         id_uses_rs1  = 1'($urandom_range(0, 1));
         id_uses_rs2  = 1'($urandom_range(0, 1));
         id_writes_rd = ($urandom_range(0, 3) != 0);
         id_is_load   = ($urandom_range(0, 3) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         reset        = ($urandom_range(0, 49) == 0);
         cycle("rand");
      end
      reset = 1'b0;
      idle("tail", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
